fp_mag_sched: RTL and testbench

Two-requester scheduler and sequencer for the floating-point magnitude unit that executes FMIN/FMAX. It arbitrates round-robin between two issue sources and drives the unit's operands, operation select and clock enable. It tracks the single in-flight operation's tag and source, and presents the result on a valid/ready port with backpressure. The block sits between the FP issue logic and the FP writeback/rounding path.

---
 rtl/fp_mag_sched.sv | 108 ++++++++++
 tb/tb_fp_mag_sched.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mag_sched.sv
// Round-robin issue scheduler for the FMIN/FMAX magnitude unit: two requesters,
// one in-flight operation, result presented on a valid/ready port with backpressure.
package fp_mag_pkg;
  typedef logic [31:0] float_t;
  typedef enum logic {FMIN_ = 1'b0, FMAX_ = 1'b1} fcmp_ops;
endpackage

module fp_mag_sched
  import fp_mag_pkg::*;
#(
  parameter int TAG_W   = 5,
  parameter int COUNT_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [1:0]         req_valid_i,
  output logic [1:0]         req_ready_o,
  input  float_t             req0_op_a_i,
  input  float_t             req0_op_b_i,
  input  float_t             req1_op_a_i,
  input  float_t             req1_op_b_i,
  input  logic               req0_fmax_i,
  input  logic               req1_fmax_i,
  input  logic [TAG_W-1:0]   req0_tag_i,
  input  logic [TAG_W-1:0]   req1_tag_i,
  input  logic               flush_i,
  output float_t             mag_operand_A_o,
  output float_t             mag_operand_B_o,
  output fcmp_ops            mag_operation_o,
  output logic               mag_clk_en_o,
  input  float_t             mag_result_i,
  input  logic               mag_invalid_i,
  input  logic               mag_overflow_i,
  input  logic               mag_underflow_i,
  output logic               res_valid_o,
  input  logic               res_ready_i,
  output float_t             res_data_o,
  output logic [TAG_W-1:0]   res_tag_o,
  output logic               res_src_o,
  output logic               res_invalid_o,
  output logic               res_overflow_o,
  output logic               res_underflow_o,
  output logic [COUNT_W-1:0] issue_cnt_o
);

  logic               stage_valid_reg;
  logic               rr_ptr_reg;
  logic [TAG_W-1:0]   tag_reg;
  logic               src_reg;
  logic [COUNT_W-1:0] issue_cnt_reg;

  logic       can_issue;
  logic       sel;
  logic [1:0] grant;

  assign can_issue = rst_n_i && !flush_i && (!stage_valid_reg || res_ready_i);

  // A lone requester wins outright; with both or neither valid, rr_ptr decides.
  always_comb begin
    sel   = rr_ptr_reg;
    grant = 2'b00;
    if (req_valid_i == 2'b01) begin
      sel = 1'b0;
    end else if (req_valid_i == 2'b10) begin
      sel = 1'b1;
    end
    if (can_issue && req_valid_i[sel]) begin
      grant = sel ? 2'b10 : 2'b01;
    end
  end

  assign req_ready_o     = grant;
  assign mag_clk_en_o    = |grant;
  assign mag_operand_A_o = sel ? req1_op_a_i : req0_op_a_i;
  assign mag_operand_B_o = sel ? req1_op_b_i : req0_op_b_i;
  assign mag_operation_o = (sel ? req1_fmax_i : req0_fmax_i) ? FMAX_ : FMIN_;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      stage_valid_reg <= 1'b0;
      rr_ptr_reg      <= 1'b0;
      tag_reg         <= '0;
      src_reg         <= 1'b0;
      issue_cnt_reg   <= '0;
    end else if (flush_i) begin
      stage_valid_reg <= 1'b0;
    end else if (|grant) begin
      stage_valid_reg <= 1'b1;
      tag_reg         <= sel ? req1_tag_i : req0_tag_i;
      src_reg         <= sel;
      rr_ptr_reg      <= !sel;
      issue_cnt_reg   <= issue_cnt_reg + 1'b1;
    end else if (stage_valid_reg && res_ready_i) begin
      stage_valid_reg <= 1'b0;
    end
  end

  // The unit holds its output while disabled, so results pass straight through.
  assign res_valid_o     = stage_valid_reg;
  assign res_data_o      = stage_valid_reg ? mag_result_i : '0;
  assign res_invalid_o   = stage_valid_reg & mag_invalid_i;
  assign res_overflow_o  = stage_valid_reg & mag_overflow_i;
  assign res_underflow_o = stage_valid_reg & mag_underflow_i;
  assign res_tag_o       = tag_reg;
  assign res_src_o       = src_reg;
  assign issue_cnt_o     = issue_cnt_reg;

endmodule

// File: tb/tb_fp_mag_sched.sv
// Scoreboard bench for fp_mag_sched with a one-stage behavioural FMIN/FMAX unit attached.
module tb_fp_mag_sched;
  localparam int TAG_W   = 5;
  localparam int COUNT_W = 4;

  typedef struct packed {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic             src;
    logic             inv;
    logic             ovf;
    logic             udf;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] req_valid = 2'b00;
  logic [1:0] req_ready;
  logic [31:0] r0a = '0, r0b = '0, r1a = '0, r1b = '0;
  logic r0f = 1'b0, r1f = 1'b0;
  logic [TAG_W-1:0] r0t = '0, r1t = '0;
  logic flush = 1'b0;
  logic [31:0] op_a, op_b;
  logic mag_op, clk_en;
  logic [31:0] mag_res = '0;
  logic mag_inv = 1'b0, mag_ovf = 1'b0, mag_udf = 1'b0;
  logic res_valid, res_ready = 1'b0;
  logic [31:0] res_data;
  logic [TAG_W-1:0] res_tag;
  logic res_src, res_inv, res_ovf, res_udf;
  logic [COUNT_W-1:0] cnt;
  logic ovf_inj = 1'b0, udf_inj = 1'b0;

  res_t sb_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fp_mag_sched #(.TAG_W(TAG_W), .COUNT_W(COUNT_W)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req0_op_a_i(r0a), .req0_op_b_i(r0b), .req1_op_a_i(r1a), .req1_op_b_i(r1b),
    .req0_fmax_i(r0f), .req1_fmax_i(r1f), .req0_tag_i(r0t), .req1_tag_i(r1t),
    .flush_i(flush), .mag_operand_A_o(op_a), .mag_operand_B_o(op_b),
    .mag_operation_o(mag_op), .mag_clk_en_o(clk_en), .mag_result_i(mag_res),
    .mag_invalid_i(mag_inv), .mag_overflow_i(mag_ovf), .mag_underflow_i(mag_udf),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_data_o(res_data),
    .res_tag_o(res_tag), .res_src_o(res_src), .res_invalid_o(res_inv),
    .res_overflow_o(res_ovf), .res_underflow_o(res_udf), .issue_cnt_o(cnt)
  );

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic f_lt(input logic [31:0] a, input logic [31:0] b);
    if (a[31] != b[31]) return a[31] && ((a[30:0] | b[30:0]) != 31'd0);
    if (!a[31]) return a[30:0] < b[30:0];
    return a[30:0] > b[30:0];
  endfunction

  function automatic logic [31:0] ref_mag(input logic [31:0] a, input logic [31:0] b, input logic fmax);
    if (is_nan(a) && is_nan(b)) return 32'h7FC00000;
    if (is_nan(a)) return b;
    if (is_nan(b)) return a;
    if (fmax) return f_lt(a, b) ? b : a;
    return f_lt(b, a) ? b : a;
  endfunction

  function automatic logic ref_inv(input logic [31:0] a, input logic [31:0] b);
    return (is_nan(a) && !a[22]) || (is_nan(b) && !b[22]);
  endfunction

  // Behavioural magnitude unit: one register stage, holds while disabled.
  always @(posedge clk) begin
    if (clk_en) begin
      mag_res <= ref_mag(op_a, op_b, mag_op);
      mag_inv <= ref_inv(op_a, op_b);
      mag_ovf <= ovf_inj;
      mag_udf <= udf_inj;
    end
  end

  // Called once per cycle at the falling edge: retire results, then record new grants.
  task automatic sb();
    res_t got, exp;
    if (!rst_n) begin
      sb_q.delete();
      return;
    end
    if (res_valid && res_ready) begin
      got = '{data: res_data, tag: res_tag, src: res_src, inv: res_inv, ovf: res_ovf, udf: res_udf};
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected: got data=%h tag=%0d src=%0d, required no result", res_data, res_tag, res_src);
      end else begin
        exp = sb_q.pop_front();
        if (got !== exp) begin
          n_bad++;
          $display("FAIL sb_result: got %h/%0d/%0d/%b%b%b required %h/%0d/%0d/%b%b%b",
                   got.data, got.tag, got.src, got.inv, got.ovf, got.udf,
                   exp.data, exp.tag, exp.src, exp.inv, exp.ovf, exp.udf);
        end else begin
          $display("result data=%h tag=%0d src=%0d flags=%b%b%b ok", got.data, got.tag, got.src, got.inv, got.ovf, got.udf);
        end
      end
    end else if (flush && res_valid && sb_q.size() > 0) begin
      void'(sb_q.pop_front());
    end
    if (req_ready[0]) begin
      exp = '{data: ref_mag(r0a, r0b, r0f), tag: r0t, src: 1'b0, inv: ref_inv(r0a, r0b), ovf: ovf_inj, udf: udf_inj};
      sb_q.push_back(exp);
    end else if (req_ready[1]) begin
      exp = '{data: ref_mag(r1a, r1b, r1f), tag: r1t, src: 1'b1, inv: ref_inv(r1a, r1b), ovf: ovf_inj, udf: udf_inj};
      sb_q.push_back(exp);
    end
  endtask

  task automatic step();
    sb();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = 2'b00; flush = 1'b0;
    @(negedge clk);
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 2'b11; res_ready = 1'b1;
    r0a = 32'h3F800000; r0b = 32'h40000000; r1a = 32'h40400000; r1b = 32'h40800000;
    @(negedge clk);
    n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL reset_ready: got %b required 00", req_ready); end
    n_cmp++; if (clk_en !== 1'b0) begin n_bad++; $display("FAIL reset_clk_en: got %b required 0", clk_en); end
    step();
    rst_n = 1'b1; req_valid = 2'b00;
    @(negedge clk);
    n_cmp++; if ({res_valid, res_data, res_tag, res_src} !== '0) begin n_bad++; $display("FAIL reset_res: got v=%b d=%h t=%0d s=%b required zeros", res_valid, res_data, res_tag, res_src); end
    n_cmp++; if ({res_inv, res_ovf, res_udf} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b%b%b required 000", res_inv, res_ovf, res_udf); end
    n_cmp++; if (cnt !== 4'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d required 0", cnt); end
    step();
  endtask

  task automatic test_single();
    req_valid = 2'b01; r0a = 32'h40000000; r0b = 32'h3F800000; r0f = 1'b1; r0t = 5'd5; res_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL single_ready: got %b required 01", req_ready); end
    n_cmp++; if ({clk_en, mag_op, op_a, op_b} !== {2'b11, 32'h40000000, 32'h3F800000}) begin n_bad++; $display("FAIL single_drive: got en=%b op=%b a=%h b=%h", clk_en, mag_op, op_a, op_b); end
    step();
    req_valid = 2'b00;
    @(negedge clk);
    n_cmp++; if ({res_valid, res_data, res_tag, res_src} !== {1'b1, 32'h40000000, 5'd5, 1'b0}) begin n_bad++; $display("FAIL single_res: got v=%b d=%h t=%0d s=%b required 1/40000000/5/0", res_valid, res_data, res_tag, res_src); end
    n_cmp++; if (cnt !== 4'd1) begin n_bad++; $display("FAIL single_cnt: got %0d required 1", cnt); end
    step();
    @(negedge clk);
    n_cmp++; if ({res_valid, res_data} !== 33'd0) begin n_bad++; $display("FAIL idle_gating: got v=%b d=%h required 0/0", res_valid, res_data); end
    step();
  endtask

  task automatic test_contention();
    logic [1:0] want;
    do_reset();
    res_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      req_valid = 2'b11;
      r0a = $urandom; r0b = $urandom; r0f = i[0]; r0t = 5'(i);
      r1a = $urandom; r1b = $urandom; r1f = !i[0]; r1t = 5'(16 + i);
      want = i[0] ? 2'b10 : 2'b01;
      @(negedge clk);
      n_cmp++; if (req_ready !== want) begin n_bad++; $display("FAIL contention_grant%0d: got %b required %b", i, req_ready, want); end
      if (i > 0) begin
        n_cmp++; if ({res_valid, res_src} !== {1'b1, !i[0]}) begin n_bad++; $display("FAIL contention_src%0d: got v=%b s=%b required 1/%b", i, res_valid, res_src, !i[0]); end
      end
      step();
    end
    req_valid = 2'b00;
    @(negedge clk);
    step();
  endtask

  task automatic test_backpressure();
    req_valid = 2'b10; r1a = 32'hBF800000; r1b = 32'h3F800000; r1f = 1'b0; r1t = 5'd9; res_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (req_ready !== 2'b10) begin n_bad++; $display("FAIL bp_issue: got %b required 10", req_ready); end
    step();
    req_valid = 2'b01; r0a = 32'h3F800000; r0b = 32'h40400000; r0f = 1'b1; r0t = 5'd3; res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if ({res_valid, res_data, res_tag, res_src} !== {1'b1, 32'hBF800000, 5'd9, 1'b1}) begin n_bad++; $display("FAIL bp_hold%0d: got v=%b d=%h t=%0d s=%b", i, res_valid, res_data, res_tag, res_src); end
      n_cmp++; if ({req_ready, clk_en} !== 3'b000) begin n_bad++; $display("FAIL bp_stall%0d: got ready=%b en=%b required 00/0", i, req_ready, clk_en); end
      step();
    end
    res_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if ({req_ready, clk_en} !== 3'b011) begin n_bad++; $display("FAIL bp_release: got ready=%b en=%b required 01/1", req_ready, clk_en); end
    step();
    req_valid = 2'b00;
    @(negedge clk);
    n_cmp++; if ({res_valid, res_data, res_src} !== {1'b1, 32'h40400000, 1'b0}) begin n_bad++; $display("FAIL bp_next: got v=%b d=%h s=%b required 1/40400000/0", res_valid, res_data, res_src); end
    step();
  endtask

  task automatic test_flush();
    req_valid = 2'b01; r0a = 32'h41000000; r0b = 32'h40000000; r0f = 1'b0; r0t = 5'd7; res_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL flush_fill: got %b required 01", req_ready); end
    step();
    req_valid = 2'b11; flush = 1'b1; r1a = 32'h40A00000; r1b = 32'h40C00000; r1f = 1'b1; r1t = 5'd11;
    @(negedge clk);
    n_cmp++; if ({req_ready, clk_en} !== 3'b000) begin n_bad++; $display("FAIL flush_block: got ready=%b en=%b required 00/0", req_ready, clk_en); end
    step();
    flush = 1'b0;
    @(negedge clk);
    n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL flush_kill: got res_valid=%b required 0", res_valid); end
    n_cmp++; if (req_ready !== 2'b10) begin n_bad++; $display("FAIL flush_rr: got %b required 10", req_ready); end
    n_cmp++; if (cnt !== 4'd9) begin n_bad++; $display("FAIL flush_cnt: got %0d required 9", cnt); end
    step();
    req_valid = 2'b00;
    @(negedge clk);
    step();
  endtask

  task automatic test_nan();
    req_valid = 2'b01; r0a = 32'hFF800001; r0b = 32'h3F800000; r0f = 1'b0; r0t = 5'd2; res_ready = 1'b1;
    @(negedge clk);
    step();
    r0a = 32'h3F800000; r0b = 32'hC0000000; r0f = 1'b1; r0t = 5'd4; ovf_inj = 1'b1; udf_inj = 1'b1;
    @(negedge clk);
    n_cmp++; if ({res_data, res_inv, res_ovf, res_udf} !== {32'h3F800000, 3'b100}) begin n_bad++; $display("FAIL nan_res: got d=%h f=%b%b%b required 3f800000/100", res_data, res_inv, res_ovf, res_udf); end
    step();
    req_valid = 2'b00; ovf_inj = 1'b0; udf_inj = 1'b0;
    @(negedge clk);
    n_cmp++; if ({res_data, res_inv, res_ovf, res_udf} !== {32'h3F800000, 3'b011}) begin n_bad++; $display("FAIL flag_pass: got d=%h f=%b%b%b required 3f800000/011", res_data, res_inv, res_ovf, res_udf); end
    step();
    @(negedge clk);
    n_cmp++; if ({res_inv, res_ovf, res_udf} !== 3'b000) begin n_bad++; $display("FAIL flag_gating: got %b%b%b required 000", res_inv, res_ovf, res_udf); end
    step();
  endtask

  task automatic test_wrap_reset();
    do_reset();
    res_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      req_valid = 2'b01; r0a = $urandom; r0b = $urandom; r0f = i[1]; r0t = 5'(i);
      @(negedge clk);
      n_cmp++; if (cnt !== 4'(i)) begin n_bad++; $display("FAIL wrap_cnt%0d: got %0d required %0d", i, cnt, i); end
      step();
    end
    req_valid = 2'b00; res_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if ({res_valid, cnt} !== {1'b1, 4'd0}) begin n_bad++; $display("FAIL wrap_zero: got v=%b cnt=%0d required 1/0", res_valid, cnt); end
    step();
    rst_n = 1'b0;
    @(negedge clk);
    step();
    rst_n = 1'b1; req_valid = 2'b11; res_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if ({res_valid, cnt} !== {1'b0, 4'd0}) begin n_bad++; $display("FAIL midop_reset: got v=%b cnt=%0d required 0/0", res_valid, cnt); end
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL reset_rr: got %b required 01", req_ready); end
    step();
    req_valid = 2'b00;
    @(negedge clk);
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_flush();
    test_nan();
    test_wrap_reset();
    n_cmp++;
    if (sb_q.size() != 0) begin n_bad++; $display("FAIL sb_drain: got %0d pending results required 0", sb_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
